// File: rtl/mem_stage.sv
// M-stage datapath of the 5-stage MIPS pipeline.
// Holds the private data memory, performs stores, and extends load data for the M/W register.
module mem_stage #(
    parameter int DM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_IR,
    input  logic [31:0] M_PC4,
    input  logic [31:0] M_PC8,
    input  logic [31:0] M_AO,
    input  logic [31:0] M_WD,
    output logic [31:0] IR_W,
    output logic [31:0] PC4_W,
    output logic [31:0] PC8_W,
    output logic [31:0] AO_W,
    output logic [31:0] DR_W,
    output logic        align_err
);

    localparam int DEPTH = 1 << DM_AW;

    typedef enum logic [3:0] {
        MEM_NONE,
        MEM_LW,
        MEM_LH,
        MEM_LHU,
        MEM_LB,
        MEM_LBU,
        MEM_SW,
        MEM_SH,
        MEM_SB
    } memOp_e;

    memOp_e           memOp;
    logic [31:0]      mem_q [DEPTH];
    logic [DM_AW-1:0] wordIdx;
    logic [1:0]       byteOff;
    logic [31:0]      rawWord;
    logic [31:0]      storeWord_d;
    logic [15:0]      loadHalf;
    logic [7:0]       loadByte;
    logic             isLoad;
    logic             isStore;
    logic             misaligned;
    logic             storeEn;
    logic             unusedBits;

    // Address bits above the memory window are ignored, so addresses wrap.
    assign wordIdx    = M_AO[DM_AW+1:2];
    assign byteOff    = M_AO[1:0];
    assign unusedBits = ^{M_IR[25:0], M_AO[31:DM_AW+2]};

    always_comb begin
        memOp = MEM_NONE;
        case (M_IR[31:26])
            6'b100011: memOp = MEM_LW;
            6'b100001: memOp = MEM_LH;
            6'b100101: memOp = MEM_LHU;
            6'b100000: memOp = MEM_LB;
            6'b100100: memOp = MEM_LBU;
            6'b101011: memOp = MEM_SW;
            6'b101001: memOp = MEM_SH;
            6'b101000: memOp = MEM_SB;
            default:   memOp = MEM_NONE;
        endcase
    end

    always_comb begin
        isLoad     = 1'b0;
        isStore    = 1'b0;
        misaligned = 1'b0;
        case (memOp)
            MEM_LW:  begin isLoad  = 1'b1; misaligned = (byteOff != 2'b00); end
            MEM_LH:  begin isLoad  = 1'b1; misaligned = byteOff[0];         end
            MEM_LHU: begin isLoad  = 1'b1; misaligned = byteOff[0];         end
            MEM_LB:  isLoad  = 1'b1;
            MEM_LBU: isLoad  = 1'b1;
            MEM_SW:  begin isStore = 1'b1; misaligned = (byteOff != 2'b00); end
            MEM_SH:  begin isStore = 1'b1; misaligned = byteOff[0];         end
            MEM_SB:  isStore = 1'b1;
            default: ;
        endcase
    end

    assign align_err = misaligned;
    assign storeEn   = isStore && !misaligned;
    assign rawWord   = mem_q[wordIdx];
    assign loadHalf  = byteOff[1] ? rawWord[31:16] : rawWord[15:0];

    always_comb begin
        loadByte = rawWord[7:0];
        case (byteOff)
            2'd0:    loadByte = rawWord[7:0];
            2'd1:    loadByte = rawWord[15:8];
            2'd2:    loadByte = rawWord[23:16];
            default: loadByte = rawWord[31:24];
        endcase
    end

    // A misaligned load returns zero; non-loads expose the raw word.
    always_comb begin
        DR_W = rawWord;
        if (isLoad && misaligned) begin
            DR_W = 32'h0;
        end else begin
            case (memOp)
                MEM_LH:  DR_W = {{16{loadHalf[15]}}, loadHalf};
                MEM_LHU: DR_W = {16'h0, loadHalf};
                MEM_LB:  DR_W = {{24{loadByte[7]}}, loadByte};
                MEM_LBU: DR_W = {24'h0, loadByte};
                default: DR_W = rawWord;
            endcase
        end
    end

    // Partial stores merge the new lane into the current word (read-modify-write in one cycle).
    always_comb begin
        storeWord_d = rawWord;
        case (memOp)
            MEM_SW: storeWord_d = M_WD;
            MEM_SH: begin
                if (byteOff[1]) storeWord_d = {M_WD[15:0], rawWord[15:0]};
                else            storeWord_d = {rawWord[31:16], M_WD[15:0]};
            end
            MEM_SB: begin
                case (byteOff)
                    2'd0:    storeWord_d = {rawWord[31:8], M_WD[7:0]};
                    2'd1:    storeWord_d = {rawWord[31:16], M_WD[7:0], rawWord[7:0]};
                    2'd2:    storeWord_d = {rawWord[31:24], M_WD[7:0], rawWord[15:0]};
                    default: storeWord_d = {M_WD[7:0], rawWord[23:0]};
                endcase
            end
            default: storeWord_d = rawWord;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: 32'h0};
        end else if (storeEn) begin
            mem_q[wordIdx] <= storeWord_d;
        end
    end

    assign IR_W  = M_IR;
    assign PC4_W = M_PC4;
    assign PC8_W = M_PC8;
    assign AO_W  = M_AO;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-level memory model checked every cycle,
// plus hand-computed literal expectations for the directed vectors.
module tb_mem_stage;

    localparam int MEM_BYTES = 4096;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_ADD = 6'h00;

    logic        clk;
    logic        reset;
    logic [31:0] irDrv, pc4Drv, pc8Drv, aoDrv, wdDrv;
    logic [31:0] IR_W, PC4_W, PC8_W, AO_W, DR_W;
    logic        align_err;

    int          checkCount;
    int          failCount;
    int          vecNo;
    bit          checkEn;
    logic [7:0]  modelMem [MEM_BYTES];

    mem_stage #(.DM_AW(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .M_IR      (irDrv),
        .M_PC4     (pc4Drv),
        .M_PC8     (pc8Drv),
        .M_AO      (aoDrv),
        .M_WD      (wdDrv),
        .IR_W      (IR_W),
        .PC4_W     (PC4_W),
        .PC8_W     (PC8_W),
        .AO_W      (AO_W),
        .DR_W      (DR_W),
        .align_err (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int accessSize(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:          return 4;
            OP_LH, OP_LHU, OP_SH:  return 2;
            OP_LB, OP_LBU, OP_SB:  return 1;
            default:               return 0;
        endcase
    endfunction

    function automatic bit isLoadOp(input logic [5:0] op);
        return op == OP_LW || op == OP_LH || op == OP_LHU || op == OP_LB || op == OP_LBU;
    endfunction

    function automatic bit modelErr(input logic [31:0] ir, input logic [31:0] ao);
        int sz;
        sz = accessSize(ir[31:26]);
        return sz != 0 && (ao % sz) != 0;
    endfunction

    function automatic logic [31:0] modelDr(input logic [31:0] ir, input logic [31:0] ao);
        int          sz;
        int          base;
        logic [31:0] val;
        sz   = accessSize(ir[31:26]);
        base = int'(ao % MEM_BYTES);
        val  = 32'h0;
        if (!isLoadOp(ir[31:26])) begin
            base = base - (base % 4);
            for (int i = 0; i < 4; i++) val = val | (32'(modelMem[base + i]) << (8 * i));
            return val;
        end
        if (modelErr(ir, ao)) return 32'h0;
        for (int i = 0; i < sz; i++) val = val | (32'(modelMem[base + i]) << (8 * i));
        if ((ir[31:26] == OP_LB || ir[31:26] == OP_LH) && val[8 * sz - 1])
            val = val | ~((32'h1 << (8 * sz)) - 32'h1);
        return val;
    endfunction

    // Model memory follows the same inputs the DUT sees at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) modelMem[i] = 8'h0;
        end else if (!isLoadOp(irDrv[31:26]) && accessSize(irDrv[31:26]) != 0 && !modelErr(irDrv, aoDrv)) begin
            for (int i = 0; i < accessSize(irDrv[31:26]); i++)
                modelMem[int'(aoDrv % MEM_BYTES) + i] = 8'(wdDrv >> (8 * i));
        end
    end

    task automatic compare32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s vec=%0d actual=%h expected=%h", name, vecNo, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            compare32("IR_W", IR_W, irDrv);
            compare32("PC4_W", PC4_W, pc4Drv);
            compare32("PC8_W", PC8_W, pc8Drv);
            compare32("AO_W", AO_W, aoDrv);
            compare32("model DR_W", DR_W, modelDr(irDrv, aoDrv));
            compare32("model align_err", {31'h0, align_err}, {31'h0, modelErr(irDrv, aoDrv)});
        end
    end

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] ao,
                                 input logic [31:0] wd, input logic rst);
        @(posedge clk);
        #1;
        vecNo++;
        reset  = rst;
        irDrv  = {op, 5'd3, 5'd7, 16'(vecNo * 37)};
        pc4Drv = 32'h0040_0000 + 32'(vecNo * 4);
        pc8Drv = pc4Drv + 32'h4;
        aoDrv  = ao;
        wdDrv  = wd;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expDr, input logic expErr);
        compare32({name, " DR_W"}, DR_W, expDr);
        compare32({name, " align_err"}, {31'h0, align_err}, {31'h0, expErr});
    endtask

    localparam logic [5:0] SWEEP_OPS [8] = '{OP_SW, OP_LW, OP_SB, OP_LB, OP_LBU, OP_SH, OP_LH, OP_LHU};

    initial begin
        checkCount = 0;
        failCount  = 0;
        vecNo      = 0;
        checkEn    = 1'b0;
        reset      = 1'b1;
        irDrv      = 32'h0;
        pc4Drv     = 32'h0;
        pc8Drv     = 32'h0;
        aoDrv      = 32'h0;
        wdDrv      = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++) modelMem[i] = 8'h0;

        @(posedge clk);
        #1;
        checkEn = 1'b1;
        reset   = 1'b0;

        applyStimulus(OP_LW, 32'h10, 32'h0, 1'b0);
        checkOutput("reset lw", 32'h0000_0000, 1'b0);

        applyStimulus(OP_SW, 32'h10, 32'h8765ABCD, 1'b0);
        checkOutput("sw aligned", 32'h0000_0000, 1'b0);
        applyStimulus(OP_LW, 32'h10, 32'h0, 1'b0);
        checkOutput("lw after sw", 32'h8765ABCD, 1'b0);
        applyStimulus(OP_LB, 32'h12, 32'h0, 1'b0);
        checkOutput("lb pos", 32'h0000_0065, 1'b0);
        applyStimulus(OP_LB, 32'h13, 32'h0, 1'b0);
        checkOutput("lb neg", 32'hFFFF_FF87, 1'b0);
        applyStimulus(OP_LBU, 32'h13, 32'h0, 1'b0);
        checkOutput("lbu", 32'h0000_0087, 1'b0);

        applyStimulus(OP_SH, 32'h12, 32'h0000F00F, 1'b0);
        applyStimulus(OP_LW, 32'h10, 32'h0, 1'b0);
        checkOutput("lw after sh", 32'hF00F_ABCD, 1'b0);
        applyStimulus(OP_LH, 32'h12, 32'h0, 1'b0);
        checkOutput("lh neg", 32'hFFFF_F00F, 1'b0);
        applyStimulus(OP_LHU, 32'h10, 32'h0, 1'b0);
        checkOutput("lhu", 32'h0000_ABCD, 1'b0);

        applyStimulus(OP_SB, 32'h11, 32'h000000EE, 1'b0);
        applyStimulus(OP_LW, 32'h10, 32'h0, 1'b0);
        checkOutput("lw after sb", 32'hF00F_EECD, 1'b0);

        applyStimulus(OP_SW, 32'h16, 32'hFFFFFFFF, 1'b0);
        checkOutput("sw misaligned", 32'h0000_0000, 1'b1);
        applyStimulus(OP_LW, 32'h14, 32'h0, 1'b0);
        checkOutput("lw word 0x14", 32'h0000_0000, 1'b0);
        applyStimulus(OP_LH, 32'h11, 32'h0, 1'b0);
        checkOutput("lh misaligned", 32'h0000_0000, 1'b1);
        applyStimulus(OP_LW, 32'h12, 32'h0, 1'b0);
        checkOutput("lw misaligned", 32'h0000_0000, 1'b1);
        applyStimulus(OP_ADD, 32'h13, 32'h0, 1'b0);
        checkOutput("non-mem raw", 32'hF00F_EECD, 1'b0);

        applyStimulus(OP_SW, 32'h20, 32'h12345678, 1'b1);
        applyStimulus(OP_LW, 32'h20, 32'h0, 1'b0);
        checkOutput("sw during reset", 32'h0000_0000, 1'b0);
        applyStimulus(OP_LW, 32'h10, 32'h0, 1'b0);
        checkOutput("cleared by reset", 32'h0000_0000, 1'b0);

        applyStimulus(OP_SW, 32'h20, 32'h0BADF00D, 1'b0);
        applyStimulus(OP_LW, 32'h1020, 32'h0, 1'b0);
        checkOutput("alias 0x1020", 32'h0BAD_F00D, 1'b0);
        applyStimulus(OP_SB, 32'hFFFF_F023, 32'h000000A5, 1'b0);
        applyStimulus(OP_LW, 32'h20, 32'h0, 1'b0);
        checkOutput("alias store", 32'hA5AD_F00D, 1'b0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(SWEEP_OPS[i % 8], 32'h40 + 32'((i * 3) % 16),
                          32'h9E37_79B9 * 32'(i + 1), 1'b0);
        end

        @(posedge clk);
        #1;
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- M-stage datapath of the 5-stage MIPS pipeline, between the E/M pipeline register and the M/W pipeline register.
- Decodes the M-stage instruction, performs word/half/byte stores into a private data memory, and produces sign- or zero-extended load data (DR).
- Passes IR, PC4, PC8 and ALU output (AO) through unchanged as the M/W register's next-state inputs.

Parameters:
- DM_AW, 10, word-address width; memory depth = 2^DM_AW words of 32 bits (default 4 KiB).

Ports:
- clk  input  1  clock; all memory writes on rising edge.
- reset  input  1  synchronous, active-high; clears data memory.
- M_IR  input  32  instruction in M stage.
- M_PC4  input  32  PC+4 of M instruction.
- M_PC8  input  32  PC+8 of M instruction.
- M_AO  input  32  ALU result; byte address for loads/stores.
- M_WD  input  32  store data (rt value, already forwarded).
- IR_W  output  32  = M_IR, to M/W register.
- PC4_W  output  32  = M_PC4.
- PC8_W  output  32  = M_PC8.
- AO_W  output  32  = M_AO.
- DR_W  output  32  extended load data, to M/W register.
- align_err  output  1  high when the M instruction is a misaligned load/store.

Behaviour:
- Opcode M_IR[31:26]: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101, sw 101011, sb 101000, sh 101001. All other opcodes are non-memory.
- Word index = M_AO[DM_AW+1:2]. Higher address bits are ignored (wrap within memory). Byte offset = M_AO[1:0].
- Read is asynchronous/combinational: DR_W reflects memory contents in the same cycle. Store takes effect at the next posedge, visible to a load in the following cycle.
- Loads:
  - lw: whole word.
  - lh/lhu: halfword at offset 0 → bits[15:0], offset 2 → bits[31:16]; sign-/zero-extend.
  - lb/lbu: byte at offset k → bits[8k+7:8k]; sign-/zero-extend.
- Non-load instructions: DR_W = raw word at index (don't-care to W; deterministic).
- Stores (at posedge, when not reset and not misaligned):
  - sw: whole word = M_WD.
  - sh: halfword selected by M_AO[1] replaced with M_WD[15:0]; other half unchanged.
  - sb: byte selected by M_AO[1:0] replaced with M_WD[7:0]; other bytes unchanged.
- Misalignment: lw/sw with M_AO[1:0]≠0, or lh/lhu/sh with M_AO[0]=1.
  - align_err = 1 (combinational).
  - Store is suppressed; memory is unchanged.
  - Load DR_W = 0.
  - Non-memory instructions never assert align_err.
- Reset: at the posedge with reset=1, all words are cleared to 0 and any concurrent store is ignored (reset wins). Afterwards DR_W = 0 for any address and align_err follows M_IR only.
- Passthrough outputs are purely combinational, with no added latency. M/W register capture supplies the single pipeline cycle.
- No stall/flush inputs: stall/flush is handled upstream by bubbling M_IR to 0 (nop → no store).

Test Plan:
- reset 1 cycle, then lw at AO=0x00000010 → DR_W=0x00000000, align_err=0.
- sw M_WD=0x8765ABCD at AO=0x10, next cycle lw AO=0x10 → DR_W=0x8765ABCD. Then lb AO=0x12 → 0x00000065; lb AO=0x13 → 0xFFFFFF87; lbu AO=0x13 → 0x00000087.
- After previous: sh M_WD=0x0000F00F at AO=0x12 → lw AO=0x10 = 0xF00FABCD. Then lh AO=0x12 → 0xFFFFF00F; lhu AO=0x10 → 0x0000ABCD.
- sb M_WD=0x000000EE at AO=0x11 → lw AO=0x10 = 0xF00FEECD.
- sw at AO=0x16 (misaligned) M_WD=0xFFFFFFFF → align_err=1, word 0x14 unchanged (0). lh AO=0x11 → align_err=1, DR_W=0.
- sw 0x12345678 at AO=0x20 in the same cycle reset=1 → lw AO=0x20 reads 0. Also an address alias check at AO=0x1020 (DM_AW=10) → reads word 0x020. Passthrough check: IR_W/PC4_W/PC8_W/AO_W equal inputs every cycle.
